// File: rtl/dmem_arb_pkg.sv
// Shared types and arbitration rule for the dual-port data-memory arbiter.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic OWNER_0 = 1'b0;
    localparam logic OWNER_1 = 1'b1;

    typedef struct packed {
        logic valid;  // some port is granted this cycle
        logic owner;  // which port (meaningful only when valid)
    } grant_t;

    // Round-robin decision with bounded bursts. burst_cnt is the number of
    // extra cycles the current owner has already held the port, so reaching
    // max_burst-1 means the owner used its full burst and must yield to a
    // waiting peer.
    function automatic grant_t next_owner(
        input state_t      state,
        input logic [1:0]  req,
        input int unsigned burst_cnt,
        input int unsigned max_burst,
        input logic        last_owner
    );
        grant_t g;
        logic   cur;
        logic   oth;
        g.valid = 1'b0;
        g.owner = last_owner;
        cur     = (state == OWN1) ? OWNER_1 : OWNER_0;
        oth     = ~cur;
        case (state)
            IDLE: begin
                if (req[0] && req[1]) begin
                    g.valid = 1'b1;
                    g.owner = ~last_owner;
                end else if (req[0]) begin
                    g.valid = 1'b1;
                    g.owner = OWNER_0;
                end else if (req[1]) begin
                    g.valid = 1'b1;
                    g.owner = OWNER_1;
                end
            end
            OWN0, OWN1: begin
                if (req[cur] && ((burst_cnt < max_burst - 1) || !req[oth])) begin
                    g.valid = 1'b1;
                    g.owner = cur;
                end else if (req[oth]) begin
                    g.valid = 1'b1;
                    g.owner = oth;
                end
            end
            default: g.valid = 1'b0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/dmem_arb_rdbuf.sv
// Per-requester read-data register: captures the combinational memory read
// on a granted read and raises rvalid for exactly the following cycle.
module dmem_arb_rdbuf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          capture,
    input  logic [DW-1:0] drdata,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);

    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    // Hold old data unless a read is issued this cycle
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        rdata_d  = rdata_q;
        rvalid_d = capture;
        if (capture) begin
            rdata_d = drdata;
        end
    end

    // Registers, cleared by synchronous reset (drops any pending rvalid)
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops sample pre-edge values together.
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU (port 0)
// and a loader/DMA master (port 1), with bounded bursts and registered reads.
// Define DMEM_ARB_STATS_EN to add grant/conflict statistics counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_we,
    output logic            m0_gnt,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_rvalid,
    input  logic            m1_req,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_we,
    output logic            m1_gnt,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_rvalid,
    output logic [AW-1:0]   daddr,
    output logic [DW-1:0]   dwdata,
    output logic [DW/8-1:0] we,
    input  logic [DW-1:0]   drdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]     grant_cnt0,
    output logic [31:0]     grant_cnt1,
    output logic [31:0]     conflict_cnt
`endif
);

    localparam int               CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    state_t           state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    grant_t           grant;
    logic             same_owner;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_1;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Arbitration decision for this cycle; reset suppresses every grant
    always_comb begin
        grant = next_owner(state_q, {m1_req, m0_req}, 32'(burst_cnt_q),
                           32'(MAX_BURST), last_owner_q);
        if (reset) begin
            grant.valid = 1'b0;
        end
    end

    // Next state: owner follows the grant, burst counter tracks repeat grants
    always_comb begin
        state_d      = IDLE;
        last_owner_d = last_owner_q;
        burst_cnt_d  = '0;
        same_owner   = grant.valid &&
                       (((state_q == OWN0) && (grant.owner == OWNER_0)) ||
                        ((state_q == OWN1) && (grant.owner == OWNER_1)));
        if (grant.valid) begin
            state_d      = (grant.owner == OWNER_1) ? OWN1 : OWN0;
            last_owner_d = grant.owner;
        end
        if (same_owner) begin
            burst_cnt_d = (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
        end
    end

    // Outputs: grants and memory-port mux, all zero when nobody is granted
    always_comb begin
        m0_gnt = grant.valid && (grant.owner == OWNER_0);
        m1_gnt = grant.valid && (grant.owner == OWNER_1);
        daddr  = '0;
        dwdata = '0;
        we     = '0;
        if (m0_gnt) begin
            daddr  = m0_addr;
            dwdata = m0_wdata;
            we     = m0_we;
        end else if (m1_gnt) begin
            daddr  = m1_addr;
            dwdata = m1_wdata;
            we     = m1_we;
        end
    end

    dmem_arb_rdbuf #(.DW(DW)) u_rdbuf0 (
        .clk     (clk),
        .reset   (reset),
        .capture (m0_gnt && (m0_we == '0)),
        .drdata  (drdata),
        .rdata   (m0_rdata),
        .rvalid  (m0_rvalid)
    );

    dmem_arb_rdbuf #(.DW(DW)) u_rdbuf1 (
        .clk     (clk),
        .reset   (reset),
        .capture (m1_gnt && (m1_we == '0)),
        .drdata  (drdata),
        .rdata   (m1_rdata),
        .rvalid  (m1_rvalid)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] grant_cnt0_q, grant_cnt0_d;
    logic [31:0] grant_cnt1_q, grant_cnt1_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    // Statistics: issued accesses per port and cycles with both requesting
    always_comb begin
        grant_cnt0_d   = grant_cnt0_q + {31'd0, m0_gnt};
        grant_cnt1_d   = grant_cnt1_q + {31'd0, m1_gnt};
        conflict_cnt_d = conflict_cnt_q + {31'd0, m0_req & m1_req};
    end

    // Statistics registers (wrap naturally at 2^32)
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt0_q   <= grant_cnt0_d;
            grant_cnt1_q   <= grant_cnt1_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt0   = grant_cnt0_q;
    assign grant_cnt1   = grant_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
